// File: rtl/hpc3_rand_gen_pkg.sv
// rtl/hpc3_rand_gen_pkg.sv - shared LFSR constants, FSM encoding and randomness width helpers
package hpc3_rand_gen_pkg;

  localparam int LFSR_W = 128;
  localparam int SEED_W = 32;

  // Feedback taps of the x^128 + x^29 + x^27 + x^2 + 1 Fibonacci LFSR
  localparam int TAP_A = 127;
  localparam int TAP_B = 28;
  localparam int TAP_C = 26;
  localparam int TAP_D = 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Same split the HPC3 gadgets use: r = {r_hi, r_lo}, each half_rnd bits wide
  function automatic int half_rnd(input int order);
    return (order * (order + 1)) / 2;
  endfunction

  function automatic int rnd_w(input int order);
    return 2 * half_rnd(order);
  endfunction

endpackage

// File: rtl/hpc3_rand_gen_if.sv
// rtl/hpc3_rand_gen_if.sv - seed / advance / randomness bundle between producer and HPC3 gadgets
interface hpc3_rand_gen_if
  import hpc3_rand_gen_pkg::*;
#(
  parameter int security_order = 1
);

  localparam int RND_W = rnd_w(security_order);

  logic [SEED_W-1:0] seed_in;
  logic              seed_valid;
  logic              seed_ready;
  logic              en;
  logic [RND_W-1:0]  r;
  logic              r_valid;

  modport master (
    output seed_in,
    output seed_valid,
    output en,
    input  seed_ready,
    input  r,
    input  r_valid
  );

  modport slave (
    input  seed_in,
    input  seed_valid,
    input  en,
    output seed_ready,
    output r,
    output r_valid
  );

endinterface

// File: rtl/hpc3_rand_gen_lfsr_step_unrolled.sv
// rtl/hpc3_rand_gen_lfsr_step_unrolled.sv - combinational STEPS-fold unrolled Fibonacci LFSR update
module lfsr_step_unrolled
  import hpc3_rand_gen_pkg::*;
#(
  parameter int STEPS = 2
) (
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] s_after
);

  logic [LFSR_W-1:0] acc;

  always_comb begin
    acc = s;
    for (int i = 0; i < STEPS; i++) begin
      acc = {acc[LFSR_W-2:0], acc[TAP_A] ^ acc[TAP_B] ^ acc[TAP_C] ^ acc[TAP_D]};
    end
    s_after = acc;
  end

endmodule

// File: rtl/hpc3_rand_gen.sv
// rtl/hpc3_rand_gen.sv - seeded, warmed-up LFSR producing fresh randomness for HPC3 gadgets
module hpc3_rand_gen
  import hpc3_rand_gen_pkg::*;
#(
  parameter int security_order = 1,
  parameter int WARMUP_CYC     = 16
) (
  input logic            clk,
  input logic            rst_n,
  hpc3_rand_gen_if.slave bus
);

  localparam int RND_W = rnd_w(security_order);

  state_t            state;
  logic [1:0]        wc;
  logic [7:0]        warm_cnt;
  logic [LFSR_W-1:0] s;
  logic [LFSR_W-1:0] s_after;
  logic [LFSR_W-1:0] s_seeded;
  logic [RND_W-1:0]  r_q;
  logic              r_valid_q;
  logic              seed_ready_q;

  lfsr_step_unrolled #(
    .STEPS (RND_W)
  ) u_step (
    .s       (s),
    .s_after (s_after)
  );

  // Next state if the offered word is accepted; the last word also guards against an all-zero seed
  always_comb begin
    s_seeded = s;
    s_seeded[{wc, 5'd0} +: SEED_W] = bus.seed_in;
    if (wc == 2'd3 && s_seeded == '0) begin
      s_seeded[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_LOAD;
      wc           <= 2'd0;
      warm_cnt     <= 8'd0;
      s            <= '0;
      r_q          <= '0;
      r_valid_q    <= 1'b0;
      seed_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.seed_valid) begin
            s  <= s_seeded;
            wc <= wc + 2'd1;
            if (wc == 2'd3) begin
              state        <= ST_WARM;
              warm_cnt     <= 8'(WARMUP_CYC);
              seed_ready_q <= 1'b0;
            end
          end
        end
        ST_WARM: begin
          s        <= s_after;
          warm_cnt <= warm_cnt - 8'd1;
          if (warm_cnt == 8'd1) begin
            r_q          <= s_after[RND_W-1:0];
            r_valid_q    <= 1'b1;
            seed_ready_q <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A reseed takes priority over an advance; wc is 0 here so the word lands in s[31:0]
          if (bus.seed_valid) begin
            s         <= s_seeded;
            wc        <= wc + 2'd1;
            r_q       <= '0;
            r_valid_q <= 1'b0;
            state     <= ST_LOAD;
          end else if (bus.en) begin
            s   <= s_after;
            r_q <= s_after[RND_W-1:0];
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.r          = r_q;
  assign bus.r_valid    = r_valid_q;
  assign bus.seed_ready = seed_ready_q;

endmodule
